pipe_stage_buf: RTL and testbench

- Parametrised successor to the fixed IF/ID latch. It is a generic pipeline stage register that carries one PC/instruction pair between stages.
- Uses a valid/ready handshake and a 2-entry skid buffer, so upstream ready never depends combinationally on downstream ready.
- Flush inserts a zero bubble. Saturating stall and flush counters support performance debug.
- Instantiated between any two pipeline stages (IF/ID first).

---
 rtl/pipe_stage_buf.sv | 126 ++++++++++++
 tb/tb_pipe_stage_buf.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buf.sv
// Generic pipeline stage register: one PC/instruction pair per entry, valid/ready
// handshake with a 2-entry skid buffer, flush-to-bubble and saturating debug counters.
module pipe_stage_buf #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic [DATA_W-1:0] in_instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_instr,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t              state_p1, state_nxt;
  logic [ADDR_W-1:0]   head_pc_p1, head_pc_nxt;
  logic [DATA_W-1:0]   head_instr_p1, head_instr_nxt;
  logic [ADDR_W-1:0]   skid_pc_p1, skid_pc_nxt;
  logic [DATA_W-1:0]   skid_instr_p1, skid_instr_nxt;
  logic [CNT_W-1:0]    stall_cnt_p1, flush_cnt_p1;
  logic                in_fire, out_fire;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Handshake decodes depend on state only, so in_ready has no path from out_ready.
  assign in_ready  = (state_p1 != FULL);
  assign out_valid = (state_p1 != EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign occupancy = 2'(state_p1);
  assign out_pc    = head_pc_p1;
  assign out_instr = head_instr_p1;
  assign stall_cnt = stall_cnt_p1;
  assign flush_cnt = flush_cnt_p1;

  always_comb begin
    state_nxt      = state_p1;
    head_pc_nxt    = head_pc_p1;
    head_instr_nxt = head_instr_p1;
    skid_pc_nxt    = skid_pc_p1;
    skid_instr_nxt = skid_instr_p1;
    if (flush) begin
      state_nxt      = EMPTY;
      head_pc_nxt    = '0;
      head_instr_nxt = '0;
      skid_pc_nxt    = '0;
      skid_instr_nxt = '0;
    end else begin
      case (state_p1)
        EMPTY: begin
          if (in_fire) begin
            state_nxt      = ONE;
            head_pc_nxt    = in_pc;
            head_instr_nxt = in_instr;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            head_pc_nxt    = in_pc;
            head_instr_nxt = in_instr;
          end else if (in_fire) begin
            state_nxt      = FULL;
            skid_pc_nxt    = in_pc;
            skid_instr_nxt = in_instr;
          end else if (out_fire) begin
            // Zero the head so an empty stage presents a NOP bubble.
            state_nxt      = EMPTY;
            head_pc_nxt    = '0;
            head_instr_nxt = '0;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_nxt      = ONE;
            head_pc_nxt    = skid_pc_p1;
            head_instr_nxt = skid_instr_p1;
            skid_pc_nxt    = '0;
            skid_instr_nxt = '0;
          end
        end
        default: begin
          state_nxt = EMPTY;
        end
      endcase
    end
  end

  // Stage register boundary: entries and counters update together.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_p1      <= EMPTY;
      head_pc_p1    <= '0;
      head_instr_p1 <= '0;
      skid_pc_p1    <= '0;
      skid_instr_p1 <= '0;
      stall_cnt_p1  <= '0;
      flush_cnt_p1  <= '0;
    end else begin
      state_p1      <= state_nxt;
      head_pc_p1    <= head_pc_nxt;
      head_instr_p1 <= head_instr_nxt;
      skid_pc_p1    <= skid_pc_nxt;
      skid_instr_p1 <= skid_instr_nxt;
      if (out_valid && !out_ready) stall_cnt_p1 <= sat_inc(stall_cnt_p1);
      if (flush)                   flush_cnt_p1 <= sat_inc(flush_cnt_p1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: streaming, backpressure, flush, reset priority,
// counter saturation (CNT_W=4) and drain-to-empty.
module tb_pipe_stage_buf;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  logic              clock = 1'b0;
  logic              reset, flush, in_valid, out_ready;
  logic              in_ready, out_valid;
  logic [ADDR_W-1:0] in_pc, out_pc;
  logic [DATA_W-1:0] in_instr, out_instr;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;

  int total = 0;
  int bad   = 0;

  pipe_stage_buf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [ADDR_W-1:0] pc, input logic [DATA_W-1:0] instr);
    in_valid = 1'b1;
    in_pc    = pc;
    in_instr = instr;
    step();
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_instr = '0;
    step(); step();
    chk("rst_in_ready",  in_ready,  1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_pc",    out_pc,    0);
    chk("rst_out_instr", out_instr, 0);
    chk("rst_occ",       occupancy, 0);
    chk("rst_stall",     stall_cnt, 0);
    chk("rst_flush",     flush_cnt, 0);
    reset = 1'b0;

    // Streaming at full throughput.
    out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      push(32'(4 * i), 32'(i));
      chk("str_valid", out_valid, 1);
      chk("str_instr", out_instr, 64'(i));
      chk("str_pc",    out_pc,    64'(4 * i));
      chk("str_occ",   occupancy, 1);
      chk("str_ready", in_ready,  1);
    end
    in_valid = 1'b0;
    step();
    chk("str_end_valid", out_valid, 0);
    chk("str_stall",     stall_cnt, 0);

    // Backpressure fill, then release.
    out_ready = 1'b0;
    push(32'h100, 32'hAAAA0000);
    chk("bp_occ1",   occupancy, 1);
    chk("bp_headA",  out_instr, 64'hAAAA0000);
    push(32'h104, 32'hBBBB0000);
    chk("bp_occ2",   occupancy, 2);
    chk("bp_nready", in_ready,  0);
    push(32'h108, 32'hCCCC0000);
    chk("bp_holdA",  out_instr, 64'hAAAA0000);
    chk("bp_occ2b",  occupancy, 2);
    step();
    chk("bp_stall3", stall_cnt, 3);
    out_ready = 1'b1;
    step();
    chk("bp_outB",   out_instr, 64'hBBBB0000);
    chk("bp_pcB",    out_pc,    64'h104);
    chk("bp_occ_b",  occupancy, 1);
    step();
    chk("bp_outC",   out_instr, 64'hCCCC0000);
    in_valid = 1'b0;
    step();
    chk("bp_empty",  occupancy, 0);
    chk("bp_stallf", stall_cnt, 3);

    // Flush while FULL with a same-cycle input.
    out_ready = 1'b0;
    push(32'h200, 32'h11110000);
    push(32'h204, 32'h22220000);
    chk("fl_full", occupancy, 2);
    flush = 1'b1;
    push(32'h208, 32'hDEAD0000);
    chk("fl_occ",    occupancy, 0);
    chk("fl_valid",  out_valid, 0);
    chk("fl_pc",     out_pc,    0);
    chk("fl_instr",  out_instr, 0);
    chk("fl_ready",  in_ready,  1);
    chk("fl_cnt",    flush_cnt, 1);
    chk("fl_stall",  stall_cnt, 5);
    flush = 1'b0; in_valid = 1'b0;
    step();
    chk("fl_nodead", out_instr, 0);
    chk("fl_occ2",   occupancy, 0);

    // Reset and flush together while FULL: reset wins.
    push(32'h300, 32'h33330000);
    push(32'h304, 32'h44440000);
    chk("rf_full", occupancy, 2);
    reset = 1'b1; flush = 1'b1;
    step();
    chk("rf_occ",   occupancy, 0);
    chk("rf_valid", out_valid, 0);
    chk("rf_ready", in_ready,  1);
    chk("rf_instr", out_instr, 0);
    chk("rf_pc",    out_pc,    0);
    chk("rf_flush", flush_cnt, 0);
    chk("rf_stall", stall_cnt, 0);
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0;

    // Saturation of both counters.
    push(32'h400, 32'h55550000);
    in_valid = 1'b0;
    chk("sat_stall0", stall_cnt, 0);
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 15) chk("sat_stall15", stall_cnt, 15);
    end
    chk("sat_stall20", stall_cnt, 15);
    chk("sat_hold",    out_instr, 64'h55550000);
    flush = 1'b1;
    for (int i = 1; i <= 20; i++) step();
    chk("sat_flush", flush_cnt, 15);
    chk("sat_occ",   occupancy, 0);
    flush = 1'b0;

    // Drain from ONE to EMPTY.
    out_ready = 1'b1;
    push(32'h500, 32'h12345678);
    chk("dr_head", out_instr, 64'h12345678);
    in_valid = 1'b0;
    step();
    chk("dr_valid", out_valid, 0);
    chk("dr_instr", out_instr, 0);
    chk("dr_occ",   occupancy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
